// File: rtl/par_accumulator_pkg.sv
// par_accumulator_pkg: FSM state encoding and sizing helpers shared by RTL and bench
package par_accumulator_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;
  function automatic int sw_f(input int w, input int kk);
    return w + $clog2(kk) + 1;
  endfunction
  function automatic int g_f(input int kk, input int ll);
    return (kk + ll - 1) / ll;
  endfunction
endpackage

// File: rtl/lane_adder.sv
// lane_adder: combinational sum of l sign/zero-extended elements into SW bits
module lane_adder #(
  parameter int W  = 8,
  parameter int SW = 13,
  parameter int l  = 3
) (
  input  logic [l*W-1:0] elems_i,
  input  logic [l-1:0]   valid_i,
  input  logic           sgn_i,
  output logic [SW-1:0]  sum_o
);
  // Extend each valid lane to SW bits and add; out-of-range lanes add nothing
  always_comb begin
    sum_o = '0;
    for (int j = 0; j < l; j++)
      if (valid_i[j]) sum_o = sum_o + {{(SW-W){sgn_i & elems_i[j*W+W-1]}}, elems_i[j*W +: W]};
  end
endmodule

// File: rtl/par_accumulator.sv
// par_accumulator: captures k elements and sums them l per cycle over G cycles
module par_accumulator
  import par_accumulator_pkg::*;
#(
  parameter int m = 4,
  parameter int n = 4,
  parameter int k = 10,
  parameter int l = 3,
  localparam int W  = m + n,
  localparam int SW = sw_f(W, k),
  localparam int G  = g_f(k, l),
  localparam int GW = (G > 1) ? $clog2(G) : 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           pl,
  input  logic           signed_mode,
  input  logic [k*W-1:0] din,
  output logic           ready,
  output logic           busy,
  output logic [SW-1:0]  sum
);
  state_e          state_q, state_d;
  logic [k*W-1:0]  data_q, data_d;
  logic            sgn_q, sgn_d;
  logic [SW-1:0]   acc_q, acc_d, sum_q, sum_d, lane_sum;
  logic [GW-1:0]   g_q, g_d;
  logic            busy_q, ready_q;
  logic [G*l*W-1:0] pad;
  logic [l*W-1:0]  grp;
  logic [l-1:0]    valid;

  // Select the current group; padding past element k-1 is masked off as invalid
  always_comb begin
    pad = '0;
    pad[k*W-1:0] = data_q;
    grp = pad[int'(g_q)*l*W +: l*W];
    for (int j = 0; j < l; j++) valid[j] = (int'(g_q) * l + j) < k;
  end

  lane_adder #(.W(W), .SW(SW), .l(l)) u_lane (
    .elems_i(grp),
    .valid_i(valid),
    .sgn_i  (sgn_q),
    .sum_o  (lane_sum)
  );

  // Next-state: accept pl outside ACC, add one group per ACC cycle, publish on the last
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    g_d     = g_q;
    sum_d   = sum_q;
    if (state_q != ACC && pl) begin
      state_d = ACC;
      data_d  = din;
      sgn_d   = signed_mode;
      acc_d   = '0;
      g_d     = '0;
    end else if (state_q == ACC) begin
      acc_d = acc_q + lane_sum;
      g_d   = g_q + GW'(1);
      if (g_q == GW'(G - 1)) begin
        state_d = DONE;
        sum_d   = acc_q + lane_sum;
        g_d     = '0;
      end
    end
  end

  // State and datapath registers; status flags registered from the next state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      data_q  <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      g_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      g_q     <= g_d;
      sum_q   <= sum_d;
      busy_q  <= state_d == ACC;
      ready_q <= state_d == DONE;
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign sum   = sum_q;
endmodule

// File: doc/par_accumulator.md
PAR_ACCUMULATOR -- requirements
Module: par_accumulator

Interface
REQ-001 Parameter m, default 4: integer bits of each element.
REQ-002 Parameter n, default 4: fractional bits of each element; element width W = m+n.
REQ-003 Parameter k, default 10: number of elements per operation, k >= 1.
REQ-004 Parameter l, default 3: lanes (elements added per cycle), 1 <= l <= k; group count G = ceil(k/l).
REQ-005 Derived localparam: SW = W + $clog2(k) + 1 (sum width, covers unsigned and signed modes).
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-008 Port pl, input, 1: parallel-load start request.
REQ-009 Port signed_mode, input, 1: 1 = elements are two's complement, 0 = unsigned; sampled with pl.
REQ-010 Port din, input, k*W: packed elements; element j is din[j*W +: W].
REQ-011 Port ready, output, 1: high while sum holds a completed result.
REQ-012 Port busy, output, 1: high while accumulating.
REQ-013 Port sum, output, SW: accumulated result.

Function
REQ-014 The FSM SHALL have states IDLE, ACC, DONE; busy = (state==ACC), ready = (state==DONE), both registered.
REQ-015 pl sampled high in IDLE or DONE SHALL capture din and signed_mode into internal registers, clear the accumulator, set group index to 0, and enter ACC.
REQ-016 pl and din SHALL be ignored in ACC; captured data SHALL NOT change until the next accepted pl.
REQ-017 Each ACC cycle SHALL add group g (elements g*l .. g*l+l-1) to the accumulator, then increment g.
REQ-018 Lane indices >= k in the last group SHALL contribute zero.
REQ-019 Each element SHALL be sign-extended to SW when the captured signed_mode=1, and zero-extended otherwise.
REQ-020 After the group G-1 addition, the FSM SHALL enter DONE; ready rises exactly G cycles after the edge that accepted pl.
REQ-021 In DONE, sum and ready SHALL hold until a new pl is accepted; on that edge ready falls and busy rises.
REQ-022 sum SHALL be 0 until the first completion; during ACC sum SHALL hold its previous value (the partial result is internal).
REQ-023 No overflow SHALL occur for any input under SW sizing; arithmetic is modulo 2^SW.

Reset
REQ-024 rstn low SHALL immediately force state=IDLE, ready=0, busy=0, sum=0, accumulator=0, group index=0, regardless of clk.
REQ-025 Reset asserted during ACC SHALL abandon the operation; no result is produced.
REQ-026 The first pl after rstn deassertion SHALL be accepted normally.

Structure
REQ-027 A shared header SHALL hold the state encodings and the SW/G width functions, reused by the testbench.
REQ-028 One sub-module, lane_adder, SHALL combinationally sum l extended elements into SW bits; par_accumulator instantiates it once.

Verification (m=4, n=4, k=10, l=3, so W=8, SW=13, G=4)
REQ-029 Unsigned, all elements 8'hFF, pl for one cycle -> ready high 4 cycles after the accepting edge, sum=2550.
REQ-030 signed_mode=1, all elements 8'h80 -> sum=13'd6912 (-1280); elements 8'h7F -> sum=1270.
REQ-031 pl asserted with new random din during ACC -> ignored; sum equals the reference sum of the first din only.
REQ-032 rstn pulsed low mid-ACC -> ready=0, busy=0, sum=0 immediately; the following pl completes correctly.
REQ-033 pl held high in DONE -> new operation accepted; ready low for exactly 4 cycles, then the new sum appears.
REQ-034 Rerun with l=10 (G=1) and l=1 (G=10) on 100 random vectors -> ready latency equals G, zero mismatches reported.
